// File: rtl/direct_line_seq.sv
// Drives one line-state write onto the host Tx port, holds it for a programmed
// number of cycles, then hands the line back with a release write.
module direct_line_seq #(
  parameter int                DATA_W       = 8,
  parameter int                CNT_W        = 16,
  parameter logic [DATA_W-1:0] CNTL_DIRECT  = 8'h00,
  parameter logic [DATA_W-1:0] CNTL_RELEASE = 8'h05
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seqStart,
  input  logic [1:0]        seqLineState,
  input  logic [CNT_W-1:0]  seqDuration,
  input  logic              seqAbort,
  input  logic              HCTxPortGnt,
  input  logic              HCTxPortRdy,
  output logic              HCTxPortReq,
  output logic              HCTxPortWEn,
  output logic [DATA_W-1:0] HCTxPortData,
  output logic [DATA_W-1:0] HCTxPortCntl,
  output logic              seqBusy,
  output logic              seqDone,
  output logic              seqAborted
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RDY_ON,
    HOLD,
    WAIT_RDY_OFF,
    RELEASE
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          line_reg, line_next;
  logic [CNT_W-1:0]    dur_reg, dur_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                abort_mark_reg, abort_mark_next;
  logic                req_reg, req_next;
  logic                wen_reg, wen_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [DATA_W-1:0]   cntl_reg, cntl_next;
  logic                done_reg, done_next;
  logic                aborted_reg, aborted_next;

  // An all-ones duration parks the sequence in HOLD until an abort arrives.
  logic hold_forever;
  assign hold_forever = &dur_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      line_reg       <= '0;
      dur_reg        <= '0;
      cnt_reg        <= '0;
      abort_mark_reg <= 1'b0;
      req_reg        <= 1'b0;
      wen_reg        <= 1'b0;
      data_reg       <= '0;
      cntl_reg       <= '0;
      done_reg       <= 1'b0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      line_reg       <= line_next;
      dur_reg        <= dur_next;
      cnt_reg        <= cnt_next;
      abort_mark_reg <= abort_mark_next;
      req_reg        <= req_next;
      wen_reg        <= wen_next;
      data_reg       <= data_next;
      cntl_reg       <= cntl_next;
      done_reg       <= done_next;
      aborted_reg    <= aborted_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    line_next       = line_reg;
    dur_next        = dur_reg;
    cnt_next        = cnt_reg;
    abort_mark_next = abort_mark_reg;
    req_next        = req_reg;
    wen_next        = 1'b0;
    data_next       = data_reg;
    cntl_next       = cntl_reg;
    done_next       = 1'b0;
    aborted_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (seqStart && !seqAbort) begin
          line_next       = seqLineState;
          dur_next        = seqDuration;
          abort_mark_next = 1'b0;
          req_next        = 1'b1;
          state_next      = WAIT_GNT;
        end
      end

      WAIT_GNT: begin
        if (seqAbort) begin
          req_next     = 1'b0;
          done_next    = 1'b1;
          aborted_next = 1'b1;
          state_next   = IDLE;
        end else if (HCTxPortGnt) begin
          state_next = WAIT_RDY_ON;
        end
      end

      WAIT_RDY_ON: begin
        if (seqAbort) begin
          req_next     = 1'b0;
          done_next    = 1'b1;
          aborted_next = 1'b1;
          state_next   = IDLE;
        end else if (HCTxPortRdy) begin
          wen_next   = 1'b1;
          data_next  = {{(DATA_W-2){1'b0}}, line_reg};
          cntl_next  = CNTL_DIRECT;
          // Zero and one both give a single hold cycle.
          cnt_next   = (dur_reg == '0) ? '0 : dur_reg - CNT_W'(1);
          state_next = HOLD;
        end
      end

      HOLD: begin
        if (seqAbort) begin
          abort_mark_next = 1'b1;
          state_next      = WAIT_RDY_OFF;
        end else if (cnt_reg == '0) begin
          state_next = WAIT_RDY_OFF;
        end else if (!hold_forever) begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      // From here on the release write is mandatory; abort is not looked at.
      WAIT_RDY_OFF: begin
        if (HCTxPortRdy) begin
          wen_next   = 1'b1;
          data_next  = '0;
          cntl_next  = CNTL_RELEASE;
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        req_next     = 1'b0;
        done_next    = 1'b1;
        aborted_next = abort_mark_reg;
        state_next   = IDLE;
      end

      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign HCTxPortReq  = req_reg;
  assign HCTxPortWEn  = wen_reg;
  assign HCTxPortData = data_reg;
  assign HCTxPortCntl = cntl_reg;
  assign seqBusy      = (state_reg != IDLE);
  assign seqDone      = done_reg;
  assign seqAborted   = aborted_reg;

endmodule

// File: tb/tb_direct_line_seq.sv
// Bench for direct_line_seq: directed vector table, randomized sequences against
// an event-time model, and reset corner cases.
module tb_direct_line_seq;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int MAXL   = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              seqStart;
  logic [1:0]        seqLineState;
  logic [CNT_W-1:0]  seqDuration;
  logic              seqAbort;
  logic              HCTxPortGnt;
  logic              HCTxPortRdy;
  logic              HCTxPortReq;
  logic              HCTxPortWEn;
  logic [DATA_W-1:0] HCTxPortData;
  logic [DATA_W-1:0] HCTxPortCntl;
  logic              seqBusy;
  logic              seqDone;
  logic              seqAborted;

  direct_line_seq dut (
    .clk(clk), .rst(rst),
    .seqStart(seqStart), .seqLineState(seqLineState), .seqDuration(seqDuration),
    .seqAbort(seqAbort), .HCTxPortGnt(HCTxPortGnt), .HCTxPortRdy(HCTxPortRdy),
    .HCTxPortReq(HCTxPortReq), .HCTxPortWEn(HCTxPortWEn),
    .HCTxPortData(HCTxPortData), .HCTxPortCntl(HCTxPortCntl),
    .seqBusy(seqBusy), .seqDone(seqDone), .seqAborted(seqAborted)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] model_data = '0;
  logic [DATA_W-1:0] model_cntl = '0;

  typedef struct {
    logic [1:0]       line;
    logic [CNT_W-1:0] dur;
    int               gnt_from;
    int               rdy_from;
    int               abort_at;
    bit               noise;
    int               exp_w1;
    int               exp_w2;
    int               exp_done;
    bit               exp_aborted;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {11'd0, HCTxPortReq, HCTxPortWEn, HCTxPortData, HCTxPortCntl, seqBusy, seqDone, seqAborted};
  endfunction

  task automatic idle_inputs();
    seqStart = 1'b0; seqAbort = 1'b0; seqLineState = 2'd0; seqDuration = '0;
    HCTxPortGnt = 1'b0; HCTxPortRdy = 1'b0;
  endtask

  // Directed run: edge 0 starts; gnt/rdy rise at fixed edges; abort is a one-edge pulse.
  task automatic run_vec(input vec_t v, input int idx);
    int w1 = -1, w2 = -1, done_e = -1, nwen = 0, ndone = 0, req_gaps = 0, orphan = 0;
    logic ab_at_done = 1'b0;
    logic [DATA_W-1:0] d1 = '0, c1 = '0, d2 = '0, c2 = '0;
    int limit = v.exp_done + 4;
    for (int n = 0; n <= limit; n++) begin
      seqStart     = (n == 0) || (v.noise && n <= v.exp_done);
      seqLineState = (n == 0) ? v.line : 2'($urandom);
      seqDuration  = (n == 0) ? v.dur : CNT_W'($urandom_range(0, 3));
      HCTxPortGnt  = (n >= v.gnt_from);
      HCTxPortRdy  = (n >= v.rdy_from);
      seqAbort     = (n == v.abort_at);
      tick();
      if (HCTxPortWEn) begin
        nwen++;
        if (w1 < 0) begin w1 = n; d1 = HCTxPortData; c1 = HCTxPortCntl; end
        else if (w2 < 0) begin w2 = n; d2 = HCTxPortData; c2 = HCTxPortCntl; end
      end
      if (seqDone) begin
        ndone++;
        if (done_e < 0) begin done_e = n; ab_at_done = seqAborted; end
      end
      if (seqAborted && !seqDone) orphan++;
      if (n < v.exp_done && !HCTxPortReq) req_gaps++;
    end
    idle_inputs();
    check($sformatf("v%0d_w1_edge", idx), w1, v.exp_w1);
    check($sformatf("v%0d_w2_edge", idx), w2, v.exp_w2);
    check($sformatf("v%0d_done_edge", idx), done_e, v.exp_done);
    check($sformatf("v%0d_aborted", idx), ab_at_done, v.exp_aborted);
    check($sformatf("v%0d_done_count", idx), ndone, 1);
    check($sformatf("v%0d_wen_count", idx), nwen, (v.exp_w1 < 0) ? 0 : 2);
    check($sformatf("v%0d_req_gaps", idx), req_gaps, 0);
    check($sformatf("v%0d_orphan_aborted", idx), orphan, 0);
    check($sformatf("v%0d_busy_end", idx), seqBusy, 1'b0);
    if (v.exp_w1 >= 0) begin
      check($sformatf("v%0d_direct_data", idx), d1, {6'd0, v.line});
      check($sformatf("v%0d_direct_cntl", idx), c1, 8'h00);
      check($sformatf("v%0d_release_data", idx), d2, 8'h00);
      check($sformatf("v%0d_release_cntl", idx), c2, 8'h05);
    end
    $display("vec %0d: w1=%0d w2=%0d done=%0d aborted=%0b", idx, w1, w2, done_e, ab_at_done);
  endtask

  // Random run: predicted event edges are derived from the input arrays, then
  // every post-edge output vector is compared.
  task automatic run_random(input int idx);
    bit g_a[MAXL];
    bit r_a[MAXL];
    logic [1:0] line;
    logic [CNT_W-1:0] dur;
    int ab, g = -1, w = -1, r = -1, end_e = -1, leave, k, n;
    bit early = 0, aborted_flag = 0, noise;
    int errs = 0;
    logic [31:0] exp_v;
    for (int i = 0; i < MAXL; i++) begin
      g_a[i] = ($urandom_range(0, 2) != 0) || (i % 5 == 0);
      r_a[i] = ($urandom_range(0, 2) != 0) || (i % 5 == 0);
    end
    line  = 2'($urandom);
    dur   = ($urandom_range(0, 9) == 9) ? '1 : CNT_W'($urandom_range(0, 6));
    noise = ($urandom_range(0, 1) == 1);
    if (&dur) ab = $urandom_range(1, 40);
    else      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : -1;

    for (n = 1; n < MAXL; n++) begin
      if (n == ab) begin early = 1; end_e = n; break; end
      if (g_a[n]) begin g = n; break; end
    end
    if (!early) begin
      for (n = g + 1; n < MAXL; n++) begin
        if (n == ab) begin early = 1; end_e = n; break; end
        if (r_a[n]) begin w = n; break; end
      end
    end
    if (early) aborted_flag = 1;
    else begin
      k = (dur == 0) ? 1 : int'(dur);
      if (ab > w && ((&dur) || ab <= w + k)) begin leave = ab; aborted_flag = 1; end
      else leave = w + k;
      for (n = leave + 1; n < MAXL; n++) if (r_a[n]) begin r = n; break; end
      end_e = r + 1;
    end

    for (n = 0; n <= end_e + 1; n++) begin
      seqStart     = (n == 0) || (noise && n <= end_e && $urandom_range(0, 3) == 0);
      seqLineState = (n == 0) ? line : 2'($urandom);
      seqDuration  = (n == 0) ? dur : CNT_W'($urandom);
      seqAbort     = (n == ab);
      HCTxPortGnt  = g_a[n];
      HCTxPortRdy  = r_a[n];
      tick();
      if (n == w) begin model_data = {6'd0, line}; model_cntl = 8'h00; end
      if (n == r) begin model_data = 8'h00; model_cntl = 8'h05; end
      exp_v = {11'd0, (n < end_e), (n == w || n == r), model_data, model_cntl,
               (n < end_e), (n == end_e), (n == end_e) && aborted_flag};
      checks++;
      if (outs() !== exp_v) begin
        failures++;
        errs++;
        $display("FAIL rnd%0d_edge%0d actual=%06h required=%06h", idx, n, outs(), exp_v);
      end
    end
    idle_inputs();
    $display("rnd %0d: D=%0h ab=%0d w=%0d r=%0d end=%0d aborted=%0b errs=%0d",
             idx, dur, ab, w, r, end_e, aborted_flag, errs);
  endtask

  vec_t tbl[10];
  int wen_cnt, bad;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            line   dur         gnt rdy abort noise w1  w2  done ab
    tbl[0] = '{2'd0, 16'd3,      0,  0, -1,   0,    2,  6,  7,  0};
    tbl[1] = '{2'd1, 16'd0,      0,  0, -1,   1,    2,  4,  5,  0};
    tbl[2] = '{2'd2, 16'd1,      0,  0, -1,   1,    2,  4,  5,  0};
    tbl[3] = '{2'd3, 16'd2,      6,  9, -1,   0,    9, 12, 13,  0};
    tbl[4] = '{2'd1, 16'd4,     10,  0,  4,   1,   -1, -1,  4,  1};
    tbl[5] = '{2'd2, 16'd4,      0,  8,  5,   0,   -1, -1,  5,  1};
    tbl[6] = '{2'd3, 16'd5,      0,  0,  4,   0,    2,  5,  6,  1};
    tbl[7] = '{2'd1, 16'hFFFF,   0,  0, 42,   1,    2, 43, 44,  1};
    tbl[8] = '{2'd2, 16'd3,      0,  0,  2,   0,   -1, -1,  2,  1};
    tbl[9] = '{2'd3, 16'd6,      0,  0, -1,   0,    2,  9, 10,  0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_after_reset", outs(), 32'd0);

    for (int i = 0; i < 40; i++) run_random(i);

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Reset while holding: everything clears and no release write follows.
    seqStart = 1'b1; seqLineState = 2'd3; seqDuration = 16'd10;
    HCTxPortGnt = 1'b1; HCTxPortRdy = 1'b1;
    tick();
    seqStart = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("hold_req_before_rst", HCTxPortReq, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_in_hold_outputs", outs(), 32'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (HCTxPortWEn || HCTxPortReq || seqBusy || seqDone) bad++;
    end
    check("no_release_after_rst", bad, 0);
    $display("reset-in-hold: quiet cycles with activity=%0d", bad);

    // Start on the very first cycle after reset is released.
    rst = 1'b1;
    tick();
    rst = 1'b0; seqStart = 1'b1; seqLineState = 2'd2; seqDuration = 16'd0;
    tick();
    seqStart = 1'b0;
    check("start_after_rst_req", {HCTxPortReq, seqBusy}, 2'b11);
    wen_cnt = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (HCTxPortWEn) wen_cnt++;
      if (seqDone) bad++;
    end
    check("start_after_rst_writes", wen_cnt, 2);
    check("start_after_rst_done", bad, 1);
    $display("start-after-reset: writes=%0d done=%0d", wen_cnt, bad);

    idle_inputs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/direct_line_seq.md
DIRECT_LINE_SEQ -- requirements
Module: direct_line_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of HCTxPortData and HCTxPortCntl.
REQ-002 SHALL have parameter CNT_W, default 16: width of the duration field and the hold counter.
REQ-003 SHALL have parameter CNTL_DIRECT, default 8'h00: Cntl code for a direct line-state write.
REQ-004 SHALL have parameter CNTL_RELEASE, default 8'h05: Cntl code that ends direct control.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 seqStart  in  1  request to start one line-state sequence.
REQ-008 seqLineState  in  2  line state to drive; sampled with seqStart.
REQ-009 seqDuration  in  CNT_W  hold length in clk cycles; sampled with seqStart.
REQ-010 seqAbort  in  1  level; ends the sequence early.
REQ-011 HCTxPortGnt  in  1  grant from the Tx port arbiter.
REQ-012 HCTxPortRdy  in  1  Tx port can accept a write this cycle.
REQ-013 HCTxPortReq  out  1  Tx port request; registered.
REQ-014 HCTxPortWEn  out  1  Tx port write strobe; registered.
REQ-015 HCTxPortData  out  DATA_W  write data; registered.
REQ-016 HCTxPortCntl  out  DATA_W  write control code; registered.
REQ-017 seqBusy  out  1  high in every state except IDLE.
REQ-018 seqDone  out  1  one-cycle pulse when a sequence ends.
REQ-019 seqAborted  out  1  one-cycle pulse when a sequence ends by abort; only together with seqDone.

Function
REQ-020 States SHALL be: IDLE, WAIT_GNT, WAIT_RDY_ON, HOLD, WAIT_RDY_OFF, RELEASE.
REQ-021 Outputs SHALL change on the clock edge after the condition that causes the change.
REQ-022 IDLE, seqStart=1, seqAbort=0 -> SHALL latch seqLineState and seqDuration, set Req=1, go to WAIT_GNT.
REQ-023 seqStart outside IDLE SHALL be ignored.
REQ-024 WAIT_GNT, Gnt=1 -> SHALL go to WAIT_RDY_ON.
REQ-025 WAIT_GNT or WAIT_RDY_ON, seqAbort=1 -> SHALL set Req=0, pulse seqDone and seqAborted, and go to IDLE, with no write.
REQ-026 WAIT_RDY_ON, Rdy=1, no abort -> SHALL write once (WEn=1, Data={zeros, latched state}, Cntl=CNTL_DIRECT), load the counter with max(D,1)-1, and go to HOLD.
REQ-027 WEn SHALL be high for exactly one cycle per write and SHALL be 0 in all other cycles.
REQ-028 HOLD SHALL decrement the counter each cycle.
REQ-029 HOLD, counter==0 -> SHALL go to WAIT_RDY_OFF; the hold time is max(D,1) cycles.
REQ-030 D equal to all ones SHALL mean hold indefinitely: the counter does not decrement and only seqAbort exits HOLD.
REQ-031 HOLD, seqAbort=1 -> SHALL go to WAIT_RDY_OFF at once and mark the sequence aborted.
REQ-032 WAIT_RDY_OFF, Rdy=1 -> SHALL write once (WEn=1, Data=0, Cntl=CNTL_RELEASE) and go to RELEASE.
REQ-033 Once a DIRECT write has been issued, seqAbort SHALL NOT skip the release write.
REQ-034 RELEASE SHALL set Req=0, pulse seqDone (and seqAborted if marked), and return to IDLE.
REQ-035 Req SHALL stay 1 from WAIT_GNT through RELEASE.
REQ-036 Data and Cntl SHALL hold their last written values between writes.
REQ-037 Gnt or Rdy while not awaited SHALL have no effect.

Reset
REQ-038 rst SHALL force IDLE, Req=0, WEn=0, Data=0, Cntl=0, counter=0, seqBusy=0, seqDone=0, seqAborted=0.
REQ-039 rst mid-sequence SHALL take priority; no release write is issued.
REQ-040 A new sequence SHALL be accepted on the first cycle after rst is released.

Verification
REQ-041 Start with state=2'b00, D=3; Gnt and Rdy tied high -> one DIRECT write with Data 0x00, Cntl 0x00; 3 HOLD cycles; RELEASE write with Cntl 0x05; one seqDone pulse; Req low.
REQ-042 D=0 -> HOLD lasts exactly 1 cycle, same as D=1.
REQ-043 Gnt delayed 5 cycles and Rdy delayed 2 cycles -> Req held throughout; WEn only after Rdy; no lost write.
REQ-044 D=16'hFFFF, abort after 40 cycles -> RELEASE write follows; seqDone and seqAborted pulse together.
REQ-045 Abort in WAIT_GNT -> no WEn; Req drops; seqDone and seqAborted pulse. seqStart pulses while busy -> ignored.
REQ-046 rst asserted in HOLD -> all outputs at reset values next cycle; no release write.
